ex_stage_buf: RTL and testbench
===============================

Name: ex_stage_buf

Overview:
- Parametrised, elastic successor to the EX/MEM pipeline register.
- Carries one execute-stage result per beat from EX to MEM over a valid/ready handshake.
- A 2-entry skid buffer keeps in_ready registered, so it has no combinational path from out_ready.
- On capture it injects the highest-priority pending exception (external interrupt, overflow, or others) and squashes the beat's side effects. It also supports synchronous flush.

Parameters:
- ADDR_W, 30, PC width (word address).
- DATA_W, 32, ALU result / store-data width.
- CTRL_W, 8, side-effect control bundle width (mem_op, ctrl_op, gpr_we, dst_addr packed by the producer); zero means no effect.
- EXP_W, 3, exception code width; code 0 = no exception.
- NUM_EXC, 2, number of injected exception sources; index 0 is highest priority.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- flush  in  1  discard all buffered and incoming beats
- in_valid  in  1  upstream beat valid
- in_ready  out  1  buffer can accept; registered
- in_pc  in  ADDR_W  PC of beat
- in_br_flag  in  1  beat is in a branch delay slot
- in_ctrl  in  CTRL_W  side-effect bundle
- in_wr_data  in  DATA_W  store data
- in_alu_out  in  DATA_W  ALU result
- in_exp_code  in  EXP_W  exception already raised upstream
- exc_req  in  NUM_EXC  exception requests sampled with the beat
- exc_code  in  NUM_EXC*EXP_W  code per request, slice i = [i*EXP_W +: EXP_W]
- out_valid  out  1  head entry valid
- out_ready  in  1  MEM accepts head
- out_pc, out_br_flag, out_ctrl, out_wr_data, out_alu_out, out_exp_code  out  (as inputs)  head entry fields

Behaviour:
- Reset and clocking: the reset line is synchronous, active-high, named reset; the clock is clk. After reset: out_valid=0, in_ready=1, and all payload outputs are 0 (out_exp_code=0).
- Handshake: a beat is accepted when in_valid&in_ready; it is emitted when out_valid&out_ready. Latency is 1 cycle, so an accepted beat appears on the outputs the next cycle when the buffer is empty.
- Storage: main register plus skid register, count 0..2.
  - in_ready(next) = (count_next < 2).
  - A simultaneous accept and emit at count=1 keeps count=1 and the main register loads the new beat.
  - At count=2 the skid entry moves to main on emit.
  - Order is strictly FIFO.
- Capture transform, applied in this priority order:
  1. Some exc_req[i] is set: take the lowest such i. Store exp_code=exc_code[i], ctrl=0, wr_data=0, alu_out=0; pc and br_flag pass through.
  2. Otherwise: store all fields verbatim, including in_exp_code.
- Flush:
  - Takes priority over accept and emit.
  - The next cycle has count=0, out_valid=0, in_ready=1, and payload registers zeroed.
  - A beat presented in the flush cycle is dropped.
  - Flush and reset asserted together behave as reset.
- Holding: with out_valid=1 and out_ready=0, every out_* field is held stable.
- Overflow guard: in_valid while in_ready=0 is ignored and no state changes.
- No bubbles: with continuous in_valid and out_ready high, throughput is 1 beat per cycle.

Optional Feature:
- Macro EX_STAGE_BUF_PERF_EN. When defined, adds these outputs:
  - perf_stall_cnt (32b): increments each cycle with out_valid&!out_ready.
  - perf_squash_cnt (32b): increments per beat captured with any exc_req.
  - Both counters saturate at all-ones and clear on reset; flush does not clear them.
- Without the macro: the ports and counters do not exist and the rest of the behaviour is identical.

Decomposition:
- Shared package holds the EXP_NO_EXP=0 constant, the exception code values (EXT_INT, OVERFLOW), and the CTRL bundle field offsets. These are shared with the decoder and MEM stage.
- Sub-module exc_prio_sel: a combinational priority encoder (NUM_EXC requests → hit flag, selected code) that is reused by the MEM stage.

Test Plan:
- Reset then single beat: pc=0x100, alu_out=0xDEADBEEF, no exc. Expect out_valid at cycle+1, fields verbatim, out_exp_code=0.
- exc_req=2'b11, codes {OVERFLOW=2, EXT_INT=1} at index {1,0}. Expect out_exp_code=1, out_ctrl=0, out_alu_out=0, pc preserved.
- out_ready=0 while 3 beats offered. Expect 2 accepted, in_ready=0 from the cycle after the 2nd accept. Release out_ready and expect beats A,B in order, then C accepted.
- Streaming 16 beats with out_ready=1. Expect 16 outputs on consecutive cycles with no gaps.
- Buffer full (count=2) plus flush with in_valid=1. Expect next cycle out_valid=0, in_ready=1, and the flushed-cycle beat never emitted.
- Perf counters (EX_STAGE_BUF_PERF_EN): 5 stalled cycles and 2 squashed beats. Expect perf_stall_cnt=5 and perf_squash_cnt=2; both counters hold across a flush.

Source files
------------

// File: rtl/ex_stage_buf_pkg.sv
// Shared definitions for the execute-to-memory hand-off: exception codes,
// side-effect bundle field offsets and the buffer occupancy encoding.
// Used by ex_stage_buf, exc_prio_sel, the decoder and the MEM stage.
package ex_stage_buf_pkg;

  // Exception codes; code 0 means the beat carries no exception.
  localparam int unsigned EXP_NO_EXP   = 0;
  localparam int unsigned EXP_EXT_INT  = 1;
  localparam int unsigned EXP_OVERFLOW = 2;

  // Side-effect bundle layout as packed by the decoder.
  // An all-zero bundle means the beat has no architectural effect.
  localparam int unsigned CTRL_DST_LSB    = 0;
  localparam int unsigned CTRL_DST_W      = 5;
  localparam int unsigned CTRL_GPR_WE_BIT = 5;
  localparam int unsigned CTRL_CTRL_OP_BIT = 6;
  localparam int unsigned CTRL_MEM_OP_BIT = 7;

  // Skid buffer occupancy.
  typedef enum logic [1:0] {
    CNT_EMPTY = 2'd0,
    CNT_ONE   = 2'd1,
    CNT_FULL  = 2'd2
  } buf_cnt_e;

  // Saturating increment for 32-bit event counters.
  function automatic logic [31:0] sat_inc32(input logic [31:0] val);
    return (val == 32'hFFFF_FFFF) ? val : val + 32'd1;
  endfunction

endpackage

// File: rtl/ex_stage_buf_exc_prio_sel.sv
// Combinational exception priority encoder: request index 0 is the most
// urgent. Returns whether any request is pending and the code of the
// winning request. Shared with the MEM stage.
module exc_prio_sel
  import ex_stage_buf_pkg::*;
#(
  parameter int unsigned NUM_EXC = 2,
  parameter int unsigned EXP_W   = 3
) (
  input  logic [NUM_EXC-1:0]       req,
  input  logic [NUM_EXC*EXP_W-1:0] code_in,
  output logic                     hit,
  output logic [EXP_W-1:0]         code_out
);

  // Scan from the lowest priority upward so the lowest set index wins.
  always_comb begin
    hit      = 1'b0;
    code_out = '0;
    for (int i = NUM_EXC - 1; i >= 0; i--) begin
      if (req[i]) begin
        hit      = 1'b1;
        code_out = code_in[i*EXP_W +: EXP_W];
      end
    end
  end

endmodule

// File: rtl/ex_stage_buf.sv
// Elastic EX/MEM pipeline register with a 2-entry skid buffer.
// in_ready is a flop, so there is no combinational path out_ready->in_ready.
// Exceptions sampled with a beat replace its exception code and zero its
// side effects at capture time. Flush discards everything.
// Optional build macro EX_STAGE_BUF_PERF_EN adds saturating stall and
// squash event counters.
module ex_stage_buf
  import ex_stage_buf_pkg::*;
#(
  parameter int unsigned ADDR_W  = 30,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned CTRL_W  = 8,
  parameter int unsigned EXP_W   = 3,
  parameter int unsigned NUM_EXC = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [ADDR_W-1:0]        in_pc,
  input  logic                     in_br_flag,
  input  logic [CTRL_W-1:0]        in_ctrl,
  input  logic [DATA_W-1:0]        in_wr_data,
  input  logic [DATA_W-1:0]        in_alu_out,
  input  logic [EXP_W-1:0]         in_exp_code,
  input  logic [NUM_EXC-1:0]       exc_req,
  input  logic [NUM_EXC*EXP_W-1:0] exc_code,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [ADDR_W-1:0]        out_pc,
  output logic                     out_br_flag,
  output logic [CTRL_W-1:0]        out_ctrl,
  output logic [DATA_W-1:0]        out_wr_data,
  output logic [DATA_W-1:0]        out_alu_out,
  output logic [EXP_W-1:0]         out_exp_code
`ifdef EX_STAGE_BUF_PERF_EN
  ,
  output logic [31:0]              perf_stall_cnt,
  output logic [31:0]              perf_squash_cnt
`endif
);

  // Payload layout: {pc, br_flag, ctrl, wr_data, alu_out, exp_code}
  localparam int unsigned PAY_W = ADDR_W + 1 + CTRL_W + 2 * DATA_W + EXP_W;

  logic [PAY_W-1:0] main_q, main_d;
  logic [PAY_W-1:0] skid_q, skid_d;
  logic [PAY_W-1:0] cap_pay;
  buf_cnt_e         count_q, count_d;
  logic             in_ready_q, in_ready_d;

  logic             exc_hit;
  logic [EXP_W-1:0] exc_sel;
  logic             accept;
  logic             emit;

  exc_prio_sel #(
    .NUM_EXC (NUM_EXC),
    .EXP_W   (EXP_W)
  ) u_exc_prio_sel (
    .req      (exc_req),
    .code_in  (exc_code),
    .hit      (exc_hit),
    .code_out (exc_sel)
  );

  assign accept = in_valid & in_ready_q;
  assign emit   = out_valid & out_ready;

  // Build the stored form of the incoming beat; a pending exception keeps
  // pc/br_flag for the handler but strips every side effect.
  always_comb begin
    if (exc_hit) begin
      cap_pay = {in_pc, in_br_flag, {CTRL_W{1'b0}}, {DATA_W{1'b0}},
                 {DATA_W{1'b0}}, exc_sel};
    end else begin
      cap_pay = {in_pc, in_br_flag, in_ctrl, in_wr_data, in_alu_out,
                 in_exp_code};
    end
  end

  // Occupancy and entry movement; flush overrides accept and emit.
  always_comb begin
    count_d = count_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      count_d = CNT_EMPTY;
      main_d  = '0;
      skid_d  = '0;
    end else begin
      case (count_q)
        CNT_EMPTY: begin
          if (accept) begin
            main_d  = cap_pay;
            count_d = CNT_ONE;
          end
        end
        CNT_ONE: begin
          if (accept && emit) begin
            main_d = cap_pay;
          end else if (accept) begin
            skid_d  = cap_pay;
            count_d = CNT_FULL;
          end else if (emit) begin
            count_d = CNT_EMPTY;
          end
        end
        CNT_FULL: begin
          // in_ready is low here, so only an emit can happen
          if (emit) begin
            main_d  = skid_q;
            count_d = CNT_ONE;
          end
        end
        default: count_d = CNT_EMPTY;
      endcase
    end
    in_ready_d = (count_d != CNT_FULL);
  end

  // Buffer state registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q    <= CNT_EMPTY;
      in_ready_q <= 1'b1;
      main_q     <= '0;
      skid_q     <= '0;
    end else begin
      count_q    <= count_d;
      in_ready_q <= in_ready_d;
      main_q     <= main_d;
      skid_q     <= skid_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = (count_q != CNT_EMPTY);
  assign {out_pc, out_br_flag, out_ctrl, out_wr_data, out_alu_out,
          out_exp_code} = main_q;

`ifdef EX_STAGE_BUF_PERF_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] squash_cnt_q, squash_cnt_d;

  // Event counters saturate and are deliberately not cleared by flush.
  always_comb begin
    stall_cnt_d  = stall_cnt_q;
    squash_cnt_d = squash_cnt_q;
    if (out_valid && !out_ready) begin
      stall_cnt_d = sat_inc32(stall_cnt_q);
    end
    if (accept && !flush && exc_hit) begin
      squash_cnt_d = sat_inc32(squash_cnt_q);
    end
  end

  // Event counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_q  <= '0;
      squash_cnt_q <= '0;
    end else begin
      stall_cnt_q  <= stall_cnt_d;
      squash_cnt_q <= squash_cnt_d;
    end
  end

  assign perf_stall_cnt  = stall_cnt_q;
  assign perf_squash_cnt = squash_cnt_q;
`else
  // No event counters in this build.
`endif

endmodule

// File: tb/tb_ex_stage_buf.sv
// Self-checking bench for ex_stage_buf: a negedge monitor keeps a scoreboard
// of expected beats (pushed on accept, popped on emit) and checks that a
// stalled head stays stable; the main sequence adds directed checks.
module tb_ex_stage_buf;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [29:0] in_pc = '0;
  logic        in_br_flag = 1'b0;
  logic [7:0]  in_ctrl = '0;
  logic [31:0] in_wr_data = '0;
  logic [31:0] in_alu_out = '0;
  logic [2:0]  in_exp_code = '0;
  logic [1:0]  exc_req = '0;
  logic [5:0]  exc_code = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [29:0] out_pc;
  logic        out_br_flag;
  logic [7:0]  out_ctrl;
  logic [31:0] out_wr_data;
  logic [31:0] out_alu_out;
  logic [2:0]  out_exp_code;
`ifdef EX_STAGE_BUF_PERF_EN
  logic [31:0] perf_stall_cnt;
  logic [31:0] perf_squash_cnt;
`endif

  int n_vec = 0;
  int n_err = 0;
  int n_emit = 0;

  logic [105:0] sb[$];
  logic         hold_v = 1'b0;
  logic [105:0] hold_bus;
  logic [105:0] out_bus;
  logic [105:0] a_bus;
  int           emit_base;

  assign out_bus = {out_pc, out_br_flag, out_ctrl, out_wr_data, out_alu_out,
                    out_exp_code};

  ex_stage_buf dut (
    .clk          (clk),
    .reset        (reset),
    .flush        (flush),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_pc        (in_pc),
    .in_br_flag   (in_br_flag),
    .in_ctrl      (in_ctrl),
    .in_wr_data   (in_wr_data),
    .in_alu_out   (in_alu_out),
    .in_exp_code  (in_exp_code),
    .exc_req      (exc_req),
    .exc_code     (exc_code),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_pc       (out_pc),
    .out_br_flag  (out_br_flag),
    .out_ctrl     (out_ctrl),
    .out_wr_data  (out_wr_data),
    .out_alu_out  (out_alu_out),
    .out_exp_code (out_exp_code)
`ifdef EX_STAGE_BUF_PERF_EN
    ,
    .perf_stall_cnt  (perf_stall_cnt),
    .perf_squash_cnt (perf_squash_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] got,
                     input logic [127:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %h, want %h", tag, got, want);
    end
  endtask

  // Reference capture transform: request 0 beats request 1.
  function automatic logic [105:0] model(
      input logic [29:0] pc, input logic br, input logic [7:0] ctrl,
      input logic [31:0] wr, input logic [31:0] alu, input logic [2:0] e,
      input logic [1:0] req, input logic [5:0] codes);
    if (req[0]) return {pc, br, 8'h00, 32'h0, 32'h0, codes[2:0]};
    if (req[1]) return {pc, br, 8'h00, 32'h0, 32'h0, codes[5:3]};
    return {pc, br, ctrl, wr, alu, e};
  endfunction

  // Scoreboard monitor.
  always @(negedge clk) begin
    if (reset || flush) begin
      sb.delete();
      hold_v = 1'b0;
    end else begin
      if (hold_v) chk("hold", out_bus, hold_bus);
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          chk("unexpected_beat", {22'h0, out_bus}, 128'h0);
        end else begin
          chk("beat", out_bus, sb.pop_front());
          n_emit++;
        end
      end
      hold_v   = out_valid && !out_ready;
      hold_bus = out_bus;
      if (in_valid && in_ready)
        sb.push_back(model(in_pc, in_br_flag, in_ctrl, in_wr_data,
                           in_alu_out, in_exp_code, exc_req, exc_code));
    end
  end

  task automatic drive(input logic [29:0] pc, input logic br,
                       input logic [7:0] ctrl, input logic [31:0] wr,
                       input logic [31:0] alu, input logic [2:0] e,
                       input logic [1:0] req, input logic [5:0] codes);
    in_pc       = pc;
    in_br_flag  = br;
    in_ctrl     = ctrl;
    in_wr_data  = wr;
    in_alu_out  = alu;
    in_exp_code = e;
    exc_req     = req;
    exc_code    = codes;
    in_valid    = 1'b1;
  endtask

  // Wait for the driven beat to be taken, then drop in_valid.
  task automatic wait_accept(input string tag);
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        exc_req  = '0;
        return;
      end
    end
    chk(tag, 0, 1);
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset state
    idle(3);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_payload", out_bus, 0);

    // Single beat, 1-cycle latency, fields verbatim
    @(posedge clk); #1;
    drive(30'h100, 1'b1, 8'h3C, 32'h0BAD_F00D, 32'hDEAD_BEEF, 3'd0, 2'b00, 6'h0);
    wait_accept("t1_accept");
    @(negedge clk);
    chk("t1_out_valid", out_valid, 1);
    chk("t1_pc", out_pc, 30'h100);
    chk("t1_alu", out_alu_out, 32'hDEAD_BEEF);
    chk("t1_ctrl", out_ctrl, 8'h3C);
    chk("t1_exp", out_exp_code, 0);
    @(negedge clk);
    chk("t1_drained", out_valid, 0);

    // Both exceptions: index 0 (EXT_INT=1) wins, side effects squashed
    @(posedge clk); #1;
    drive(30'h2A4, 1'b0, 8'hA5, 32'h1234, 32'h5555, 3'd4, 2'b11, {3'd2, 3'd1});
    wait_accept("t2_accept");
    @(negedge clk);
    chk("t2_exp", out_exp_code, 1);
    chk("t2_ctrl", out_ctrl, 0);
    chk("t2_alu", out_alu_out, 0);
    chk("t2_wr", out_wr_data, 0);
    chk("t2_pc", out_pc, 30'h2A4);
    @(posedge clk); #1;
    drive(30'h2A8, 1'b1, 8'h11, 32'h77, 32'h88, 3'd0, 2'b10, {3'd2, 3'd1});
    wait_accept("t2b_accept");
    @(negedge clk);
    chk("t2b_exp", out_exp_code, 2);
    chk("t2b_br", out_br_flag, 1);

    // Back-pressure: 2 accepted, third held until MEM drains
    @(posedge clk); #1;
    out_ready = 1'b0;
    drive(30'hA, 1'b0, 8'h0A, 32'hA0, 32'hAA, 3'd0, 2'b00, 6'h0);
    wait_accept("t3_a");
    drive(30'hB, 1'b0, 8'h0B, 32'hB0, 32'hBB, 3'd0, 2'b00, 6'h0);
    wait_accept("t3_b");
    drive(30'hC, 1'b0, 8'h0C, 32'hC0, 32'hCC, 3'd0, 2'b00, 6'h0);
    repeat (2) begin
      @(negedge clk);
      chk("t3_full_ready", in_ready, 0);
      chk("t3_head_pc", out_pc, 30'hA);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    wait_accept("t3_c");
    idle(4);
    chk("t3_empty", out_valid, 0);

    // Streaming 16 beats with no bubbles
    emit_base = n_emit;
    for (int i = 0; i < 16; i++) begin
      drive(30'h400 + 30'(i), i[0], 8'(i), 32'(i * 3), 32'(i * 7), 3'(i % 5),
            2'b00, 6'h0);
      @(negedge clk);
      chk("strm_ready", in_ready, 1);
      if (i > 0) chk("strm_out_valid", out_valid, 1);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    @(negedge clk);
    chk("strm_last_valid", out_valid, 1);
    @(negedge clk); #1;
    chk("strm_done", out_valid, 0);
    chk("strm_count", n_emit - emit_base, 16);

    // Flush while full with a beat presented
    @(posedge clk); #1;
    out_ready = 1'b0;
    drive(30'h501, 1'b0, 8'h01, 32'h1, 32'h1, 3'd0, 2'b00, 6'h0);
    wait_accept("fl_a");
    drive(30'h502, 1'b0, 8'h02, 32'h2, 32'h2, 3'd0, 2'b00, 6'h0);
    wait_accept("fl_b");
    drive(30'h503, 1'b1, 8'h03, 32'h3, 32'h3, 3'd0, 2'b00, 6'h0);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    chk("fl_out_valid", out_valid, 0);
    chk("fl_in_ready", in_ready, 1);
    chk("fl_payload", out_bus, 0);
    out_ready = 1'b1;
    idle(4);
    chk("fl_no_emit", out_valid, 0);

    // Random traffic with occasional exceptions and flushes
    for (int i = 0; i < 400; i++) begin
      out_ready   = ($urandom_range(0, 3) != 0);
      in_valid    = ($urandom_range(0, 3) != 0);
      in_pc       = 30'($urandom);
      in_br_flag  = 1'($urandom);
      in_ctrl     = 8'($urandom);
      in_wr_data  = $urandom;
      in_alu_out  = $urandom;
      in_exp_code = 3'($urandom);
      exc_req     = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b00;
      exc_code    = 6'($urandom);
      flush       = ($urandom_range(0, 31) == 0);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    flush    = 1'b0;
    exc_req  = '0;
    out_ready = 1'b1;
    idle(4);
    chk("rand_drained", out_valid, 0);
    chk("rand_sb_empty", sb.size(), 0);

`ifdef EX_STAGE_BUF_PERF_EN
    // Event counters: 5 stalled cycles, 2 squashed beats
    out_ready = 1'b0;
    reset = 1'b1;
    idle(1);
    reset = 1'b0;
    @(negedge clk);
    chk("perf_rst_stall", perf_stall_cnt, 0);
    chk("perf_rst_squash", perf_squash_cnt, 0);
    @(posedge clk); #1;
    drive(30'h600, 1'b0, 8'hFF, 32'h1, 32'h2, 3'd0, 2'b01, {3'd2, 3'd1});
    wait_accept("perf_a");
    repeat (5) @(posedge clk);
    #1;
    out_ready = 1'b1;
    drive(30'h604, 1'b0, 8'hFF, 32'h3, 32'h4, 3'd0, 2'b10, {3'd2, 3'd1});
    wait_accept("perf_b");
    idle(3);
    chk("perf_stall", perf_stall_cnt, 5);
    chk("perf_squash", perf_squash_cnt, 2);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    @(negedge clk);
    chk("perf_stall_flush", perf_stall_cnt, 5);
    chk("perf_squash_flush", perf_squash_cnt, 2);
`endif

    idle(2);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Absolute time bound.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running, want done");
    $fatal(1, "timeout");
  end

endmodule
